// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types, constants and fetch helpers
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0] ALIGN_OK = 2'b00;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // A target is fetchable when word aligned and inside the instruction memory.
    function automatic logic fetch_ok(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] limit);
        return (addr[1:0] == ALIGN_OK) && (addr < limit);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory, control and decode-side signals of the fetch stage
interface fetch_unit_if;
    import core_pkg::*;

    logic [XLEN-1:0] imem_addr_o;
    logic [XLEN-1:0] imem_rdata_i;
    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic            instr_valid_o;
    logic            fault_o;
    logic [XLEN-1:0] fault_pc_o;

    // Fetch unit side.
    modport slave (
        output imem_addr_o,
        input  imem_rdata_i,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_o,
        output instr_pc_o,
        output instr_valid_o,
        output fault_o,
        output fault_pc_o
    );

    // Surrounding pipeline / memory side.
    modport master (
        input  imem_addr_o,
        output imem_rdata_i,
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_o,
        input  instr_pc_o,
        input  instr_valid_o,
        input  fault_o,
        input  fault_pc_o
    );

endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and fetch sequencing ahead of instruction memory
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_WORDS = 256
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);

    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_WORDS * 4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic            rsp_valid_q;
    fetch_state_e    state_q;
    logic [XLEN-1:0] fault_pc_q;

    logic            target_ok;

    assign target_ok = fetch_ok(bus.redirect_pc_i, IMEM_LIMIT);

    // Re-present last cycle's address while held (stall without redirect, or halted)
    // so the registered memory output repeats the same word.
    always_comb begin
        bus.imem_addr_o = pc_q;
        if ((bus.stall_i && !bus.redirect_i) || (state_q == HALT)) begin
            bus.imem_addr_o = rsp_pc_q;
        end
    end

    assign bus.instr_o       = bus.imem_rdata_i;
    assign bus.instr_pc_o    = rsp_pc_q;
    assign bus.instr_valid_o = rsp_valid_q && (state_q == RUN);
    assign bus.fault_o       = (state_q == HALT);
    assign bus.fault_pc_o    = fault_pc_q;

    // Fetch sequencer: redirect beats stall, stall beats sequential advance; HALT is terminal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            rsp_valid_q <= 1'b0;
            state_q     <= RUN;
            fault_pc_q  <= '0;
        end else if (state_q == RUN) begin
            if (bus.redirect_i && !target_ok) begin
                state_q     <= HALT;
                fault_pc_q  <= bus.redirect_pc_i;
                rsp_valid_q <= 1'b0;
            end else if (bus.redirect_i) begin
                // The word returning next cycle belongs to the old path: squash it.
                pc_q        <= bus.redirect_pc_i;
                rsp_valid_q <= 1'b0;
            end else if (bus.stall_i) begin
                pc_q        <= pc_q;
            end else if (pc_q >= IMEM_LIMIT) begin
                state_q     <= HALT;
                fault_pc_q  <= pc_q;
                rsp_valid_q <= 1'b0;
            end else begin
                rsp_pc_q    <= pc_q;
                rsp_valid_q <= 1'b1;
                pc_q        <= pc_q + XLEN'(4);
            end
        end
    end

endmodule
